dmem_access_unit: RTL and testbench

- Memory-stage responder for the data-memory control fields the decoder produces for each load or store: write enable, sign and width.
- Turns a byte-addressed request of byte, halfword or word size into one or two word-aligned bus beats with byte enables on a req/ack data-memory port.
- Aligns and extends load data back to 32 bits.
- Stalls the pipeline until the access completes. Misaligned accesses that cross a word boundary are split into two beats.

---
 rtl/dmem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_dmem_access_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Memory-stage data-memory responder: turns a byte/half/word load or store into
// one or two word-aligned req/ack bus beats and returns the aligned, extended load result.
module dmem_access_unit #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_sign,
  input  logic [1:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] width_be(input logic [1:0] w);
    case (w)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] width_mask(input logic [1:0] w);
    case (w)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // An access crosses a word boundary when its last byte lands past lane 3.
  function automatic logic crosses(input logic [1:0] w, input logic [1:0] off);
    return ({1'b0, width_bytes(w)} + {2'b00, off}) > 4'd4;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, beat0_rdata_q;
  logic [1:0]  width_q;
  logic        we_q, sign_q, reject_q;

  logic [1:0]  off_q;
  logic [31:0] word_addr;
  logic        cross_q, req_reject, last_ack;
  logic [7:0]  be_span;
  logic [63:0] wdata_span, load_span;
  logic [31:0] load_word, load_ext;

  assign off_q      = addr_q[1:0];
  assign word_addr  = {addr_q[31:2], 2'b00};
  assign cross_q    = crosses(width_q, off_q);
  assign req_reject = !SPLIT_EN && crosses(req_width, req_addr[1:0]);

  // Both beats are slices of one 8-lane window shifted by the byte offset.
  assign be_span    = {4'b0000, width_be(width_q)} << off_q;
  assign wdata_span = {32'h0, wdata_q & width_mask(width_q)} << {off_q, 3'b000};

  assign load_span  = (state_q == BEAT1) ? {mem_rdata, beat0_rdata_q} : {32'h0, mem_rdata};
  assign load_word  = 32'(load_span >> {off_q, 3'b000});
  assign last_ack   = mem_ack && ((state_q == BEAT0 && !cross_q) || state_q == BEAT1);

  always_comb begin
    case (width_q)
      2'b00:   load_ext = sign_q ? {24'h0, load_word[7:0]}  : {{24{load_word[7]}}, load_word[7:0]};
      2'b01:   load_ext = sign_q ? {16'h0, load_word[15:0]} : {{16{load_word[15]}}, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    rvalid    = 1'b0;
    misalign  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          state_d = req_reject ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr;
        mem_be    = be_span[3:0];
        mem_wdata = wdata_span[31:0];
        if (mem_ack) state_d = cross_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr + 32'd4;
        mem_be    = be_span[7:4];
        mem_wdata = wdata_span[63:32];
        if (mem_ack) state_d = RESP;
      end
      default: begin
        // A rejected access produces no data, so it raises misalign instead of rvalid.
        rvalid   = !we_q && !reject_q;
        misalign = reject_q;
        state_d  = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      width_q       <= 2'b00;
      we_q          <= 1'b0;
      sign_q        <= 1'b0;
      reject_q      <= 1'b0;
      beat0_rdata_q <= 32'h0;
      rdata         <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        width_q  <= req_width;
        we_q     <= req_we;
        sign_q   <= req_sign;
        reject_q <= req_reject;
      end
      if (state_q == BEAT0 && mem_ack) beat0_rdata_q <= mem_rdata;
      // The result is loaded on the final ack so it is already valid during the RESP cycle.
      if (last_ack && !we_q) rdata <= load_ext;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases plus randomized accesses
// checked against a byte-lane reference model and a req/ack memory responder.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_valid_ns = 1'b0;
  logic        req_we = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        stall, rvalid, misalign, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        stall_ns, rvalid_ns, misalign_ns, mem_req_ns, mem_we_ns, mem_ack_ns;
  logic [31:0] rdata_ns, mem_addr_ns, mem_wdata_ns, mem_rdata_ns;
  logic [3:0]  mem_be_ns;

  assign mem_ack_ns   = mem_req_ns;
  assign mem_rdata_ns = 32'hCAFE_F00D;

  dmem_access_unit #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_sign(req_sign),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rvalid(rvalid), .rdata(rdata), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  dmem_access_unit #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_we(req_we), .req_sign(req_sign),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall_ns), .rvalid(rvalid_ns), .rdata(rdata_ns), .misalign(misalign_ns),
    .mem_req(mem_req_ns), .mem_we(mem_we_ns), .mem_addr(mem_addr_ns), .mem_be(mem_be_ns),
    .mem_wdata(mem_wdata_ns), .mem_ack(mem_ack_ns), .mem_rdata(mem_rdata_ns)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // ---------------- memory model and bus responder ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:0], wa[31:16]} ^ 32'hA5C3_1E97;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] b);
    logic [31:0] w;
    w = mem_word({b[31:2], 2'b00});
    return w[8*b[1:0] +: 8];
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          cycles;
  } beat_t;

  beat_t       beats[$];
  int          wait_cycles = 0;
  int          wait_cnt = 0;
  bit          hold_second = 1'b0;
  int          unstable = 0;
  int          rvalid_seen = 0;
  int          ns_req_seen = 0;
  logic        prev_pending = 1'b0;
  logic [68:0] prev_bus = '0;

  always @(negedge clk) begin
    logic [31:0] w;
    if (rvalid) rvalid_seen++;
    if (mem_req_ns) ns_req_seen++;
    if (mem_req && prev_pending && {mem_we, mem_addr, mem_be, mem_wdata} !== prev_bus) unstable++;
    if (mem_req && !rst) begin
      if (wait_cnt >= wait_cycles && !(hold_second && beats.size() == 1)) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        beats.push_back('{mem_addr, mem_be, mem_we, mem_wdata, wait_cnt + 1});
        if (mem_we) begin
          w = mem_word(mem_addr);
          for (int l = 0; l < 4; l++) if (mem_be[l]) w[8*l +: 8] = mem_wdata[8*l +: 8];
          mem[mem_addr] = w;
        end
        wait_cnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
    prev_pending = mem_req && !mem_ack;
    prev_bus     = {mem_we, mem_addr, mem_be, mem_wdata};
  end

  // ---------------- one access against the reference model ----------------
  task automatic do_access(input logic we, input logic sign, input logic [1:0] width,
                           input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int          size, nbeats, exp_stall, stall_n;
    logic [31:0] w0, exp_rd, ld;
    logic [3:0]  exp_be [2];
    logic [31:0] exp_wd [2];
    size   = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    w0     = {addr[31:2], 2'b00};
    nbeats = 1;
    ld     = 32'h0;
    for (int b = 0; b < 2; b++) begin exp_be[b] = 4'b0000; exp_wd[b] = 32'h0; end
    for (int i = 0; i < size; i++) begin
      int pos, bt, lane;
      pos  = int'(addr[1:0]) + i;
      bt   = pos / 4;
      lane = pos % 4;
      if (bt == 1) nbeats = 2;
      exp_be[bt][lane]       = 1'b1;
      exp_wd[bt][8*lane +: 8] = wdata[8*i +: 8];
      ld[8*i +: 8]            = mem_byte(w0 + 32'(pos));
    end
    if (size == 1)      exp_rd = sign ? {24'h0, ld[7:0]}  : {{24{ld[7]}}, ld[7:0]};
    else if (size == 2) exp_rd = sign ? {16'h0, ld[15:0]} : {{16{ld[15]}}, ld[15:0]};
    else                exp_rd = ld;
    exp_stall = 1 + nbeats * (wait_cycles + 1);

    @(negedge clk);
    beats.delete();
    req_we = we; req_sign = sign; req_width = width; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    stall_n = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!stall) break;
      stall_n++;
      @(negedge clk);
    end
    check({tag, " stall cycles"}, 32'(stall_n), 32'(exp_stall));
    check({tag, " rvalid"}, 32'(rvalid), 32'(!we));
    check({tag, " misalign"}, 32'(misalign), 32'h0);
    if (!we) check({tag, " rdata"}, rdata, exp_rd);
    check({tag, " beats"}, 32'(beats.size()), 32'(nbeats));
    for (int b = 0; b < nbeats; b++) begin
      if (b < beats.size()) begin
        check($sformatf("%s b%0d addr", tag, b), beats[b].addr, w0 + 32'(4 * b));
        check($sformatf("%s b%0d be", tag, b), 32'(beats[b].be), 32'(exp_be[b]));
        check($sformatf("%s b%0d we", tag, b), 32'(beats[b].we), 32'(we));
        if (we) check($sformatf("%s b%0d wdata", tag, b), beats[b].wdata, exp_wd[b]);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " rvalid pulse"}, 32'(rvalid), 32'h0);
    check({tag, " idle stall"}, 32'(stall), 32'h0);
    if (!we) check({tag, " rdata hold"}, rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rv_before;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst stall", 32'(stall), 32'h0);
    check("rst rvalid", 32'(rvalid), 32'h0);
    check("rst rdata", rdata, 32'h0);
    check("rst misalign", 32'(misalign), 32'h0);
    check("rst mem_req", 32'(mem_req), 32'h0);
    check("rst mem_we/be", {27'h0, mem_we, mem_be}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst ns outputs", {26'h0, stall_ns, rvalid_ns, misalign_ns, mem_req_ns, mem_we_ns, |rdata_ns}, 32'h0);
    rst = 1'b0;

    // 1: LB / LBU at 0x103
    mem[32'h100] = 32'h8899_AABB;
    wait_cycles = 0;
    do_access(1'b0, 1'b0, 2'b00, 32'h103, 32'h0, "t1 lb");
    check("t1 lb literal", rdata, 32'hFFFF_FF88);
    check("t1 be literal", beats.size() > 0 ? 32'(beats[0].be) : 32'hF, 32'h8);
    do_access(1'b0, 1'b1, 2'b00, 32'h103, 32'h0, "t1 lbu");
    check("t1 lbu literal", rdata, 32'h0000_0088);

    // 2: LH crossing at 0x103
    mem[32'h104] = 32'h1122_3344;
    do_access(1'b0, 1'b0, 2'b01, 32'h103, 32'h0, "t2 lh");
    check("t2 lh literal", rdata, 32'h0000_4488);
    check("t2 b1 be literal", beats.size() > 1 ? 32'(beats[1].be) : 32'hF, 32'h1);

    // 3: SW crossing at 0x102
    rv_before = rvalid_seen;
    do_access(1'b1, 1'b0, 2'b10, 32'h102, 32'hDEAD_BEEF, "t3 sw");
    check("t3 b0 wdata literal", beats.size() > 0 ? beats[0].wdata : 32'h1, 32'hBEEF_0000);
    check("t3 b1 wdata literal", beats.size() > 1 ? beats[1].wdata : 32'h1, 32'h0000_DEAD);
    check("t3 no rvalid", 32'(rvalid_seen), 32'(rv_before));

    // 4: SB with three wait cycles
    wait_cycles = 3;
    unstable = 0;
    do_access(1'b1, 1'b0, 2'b00, 32'h101, 32'h1234_565A, "t4 sb");
    check("t4 wdata literal", beats.size() > 0 ? beats[0].wdata : 32'h1, 32'h0000_5A00);
    check("t4 req cycles", beats.size() > 0 ? 32'(beats[0].cycles) : 32'h0, 32'd4);
    check("t4 bus stable", 32'(unstable), 32'h0);
    wait_cycles = 0;

    // 5: LW wrapping past the top of the address space, then the non-split variant
    do_access(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, "t5 lw");
    check("t5 b1 addr literal", beats.size() > 1 ? beats[1].addr : 32'h1, 32'h0);
    @(negedge clk);
    req_we = 1'b0; req_sign = 1'b0; req_width = 2'b10; req_addr = 32'hFFFF_FFFE;
    req_valid_ns = 1'b1;
    #1 check("t5 ns accept stall", 32'(stall_ns), 32'h1);
    @(negedge clk);
    #1;
    check("t5 ns misalign", 32'(misalign_ns), 32'h1);
    check("t5 ns resp stall", 32'(stall_ns), 32'h0);
    req_valid_ns = 1'b0;
    @(negedge clk);
    #1;
    check("t5 ns misalign pulse", 32'(misalign_ns), 32'h0);
    check("t5 ns no mem_req", 32'(ns_req_seen), 32'h0);
    req_addr = 32'h40;
    req_valid_ns = 1'b1;
    @(negedge clk);
    #1 check("t5 ns aligned beat", 32'(mem_req_ns), 32'h1);
    @(negedge clk);
    #1;
    check("t5 ns aligned rvalid", 32'(rvalid_ns), 32'h1);
    check("t5 ns aligned rdata", rdata_ns, 32'hCAFE_F00D);
    check("t5 ns aligned misalign", 32'(misalign_ns), 32'h0);
    req_valid_ns = 1'b0;

    // 6: reset while the second beat is waiting
    hold_second = 1'b1;
    @(negedge clk);
    beats.delete();
    req_we = 1'b0; req_sign = 1'b0; req_width = 2'b01; req_addr = 32'h103;
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (beats.size() == 1 && mem_req && mem_addr === 32'h104) break;
    end
    @(negedge clk);
    #1;
    check("t6 beat1 pending", {31'h0, mem_req}, 32'h1);
    check("t6 beat1 addr", mem_addr, 32'h104);
    rv_before = rvalid_seen;
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("t6 mem_req dropped", 32'(mem_req), 32'h0);
    check("t6 stall dropped", 32'(stall), 32'h0);
    check("t6 rdata cleared", rdata, 32'h0);
    check("t6 rvalid", 32'(rvalid), 32'h0);
    rst = 1'b0;
    hold_second = 1'b0;
    @(negedge clk);
    #1 check("t6 no rvalid after reset", 32'(rvalid_seen), 32'(rv_before));
    do_access(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, "t6 lw0");
    check("t6 lw0 literal", rdata, mem_word(32'h0));

    // Randomized accesses around a normal region and the address-space wrap
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                      : 32'h100 + 32'($urandom_range(0, 63));
      wait_cycles = $urandom_range(0, 2);
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                a, $urandom, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
